// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_pkg
// Description : Shared types and helpers for the byte-addressed data memory:
//               access-size and FSM state enums, byte-count, lane-mask and
//               load-extension functions.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

  localparam int c_BYTE_W = 8;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_RSV = 2'd3
  } size_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_e;

  // Number of bytes touched by an access of the given size (8 for reserved).
  function automatic logic [3:0] byte_count(input size_e size);
    return 4'd1 << size;
  endfunction

  // Contiguous lane mask of byte_count(size) ones, right-justified.
  function automatic logic [7:0] lane_mask(input size_e size);
    return 8'((9'd1 << byte_count(size)) - 9'd1);
  endfunction

  // Sign- or zero-extend a right-justified load value from its access size.
  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input size_e       size,
                                              input logic        uns);
    case (size)
      SZ_B:    return uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}},  raw[7:0]};
      SZ_H:    return uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_bank.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_bank
// Description : DEPTH x NB-lane byte RAM with per-lane write enables and a
//               synchronous (1-cycle) read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_bank #(
  parameter int DEPTH  = 1024,
  parameter int NB     = 2,
  parameter int DATA_W = 16,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic [AW-1:0]     i_addr,
  input  logic [NB-1:0]     i_be,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  for (genvar i = 0; i < NB; i++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;

    // Lane write on enable; read returns the pre-write contents of the word.
    always_ff @(posedge clk) begin
      if (i_be[i]) r_mem[i_addr] <= i_wdata[8*i +: 8];
      r_q <= r_mem[i_addr];
    end

    assign o_rdata[8*i +: 8] = r_q;
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl
// Description : Byte-addressed data memory controller. Steers byte/half/word
//               stores onto RAM lanes, gathers and extends loads, and splits
//               word-crossing accesses into two consecutive RAM cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int NB     = DATA_W / c_BYTE_W;
  localparam int OFF_W  = $clog2(NB);
  localparam int WORD_W = ADDR_W - OFF_W;
  localparam int DEPTH  = 1 << WORD_W;
  localparam int BE2_W  = 2 * NB;
  localparam int D2_W   = 2 * DATA_W;

  // Request decode
  size_e             w_size;
  logic [3:0]        w_bc;
  logic              w_err;
  logic [OFF_W-1:0]  w_off;
  logic [WORD_W-1:0] w_word;
  logic [4:0]        w_end;
  logic              w_cross;
  logic              w_fire;
  logic [BE2_W-1:0]  w_be_wide;
  logic [D2_W-1:0]   w_wdata_wide;

  // RAM port
  logic [WORD_W-1:0] w_bank_addr;
  logic [NB-1:0]     w_bank_be;
  logic [DATA_W-1:0] w_bank_wdata;
  logic [DATA_W-1:0] w_bank_rdata;

  // Held request and response state
  state_e            r_state;
  logic [WORD_W-1:0] r_next_word;
  logic [NB-1:0]     r_hi_be;
  logic [DATA_W-1:0] r_hi_wdata;
  logic              r_op_we;
  logic              r_op_uns;
  logic              r_op_cross;
  size_e             r_op_size;
  logic [OFF_W-1:0]  r_op_off;
  logic [DATA_W-1:0] r_lo_rdata;
  logic              r_rsp_valid;
  logic              r_rsp_err;

  // Gather path
  logic [D2_W-1:0]   w_gather;
  logic [DATA_W-1:0] w_raw;

  assign req_ready = (r_state == IDLE);
  assign w_fire    = req_valid && req_ready;

  assign w_size  = size_e'(req_size);
  assign w_bc    = byte_count(w_size);
  assign w_err   = (w_size == SZ_RSV) || (w_bc > 4'(NB));
  assign w_off   = req_addr[OFF_W-1:0];
  assign w_word  = req_addr[ADDR_W-1:OFF_W];
  assign w_end   = 5'(w_off) + 5'(w_bc);
  assign w_cross = !w_err && (w_end > 5'(NB));

  // Lanes and data spread over two words; the upper word only matters on a split.
  assign w_be_wide    = BE2_W'(lane_mask(w_size)) << w_off;
  assign w_wdata_wide = D2_W'(req_wdata) << {w_off, 3'b000};

  // RAM port steering: the held second half in SPLIT, otherwise the live request.
  always_comb begin
    w_bank_addr  = w_word;
    w_bank_be    = '0;
    w_bank_wdata = w_wdata_wide[DATA_W-1:0];
    if (r_state == SPLIT) begin
      w_bank_addr  = r_next_word;
      w_bank_be    = r_op_we ? r_hi_be : '0;
      w_bank_wdata = r_hi_wdata;
    end else if (w_fire && !w_err && req_we) begin
      w_bank_be    = w_be_wide[NB-1:0];
    end
  end

  data_mem_bank #(
    .DEPTH  (DEPTH),
    .NB     (NB),
    .DATA_W (DATA_W),
    .AW     (WORD_W)
  ) u_bank (
    .clk     (clk),
    .i_addr  (w_bank_addr),
    .i_be    (w_bank_be),
    .i_wdata (w_bank_wdata),
    .o_rdata (w_bank_rdata)
  );

  // Controller FSM: captures the request, sequences the split, times the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_next_word <= '0;
      r_hi_be     <= '0;
      r_hi_wdata  <= '0;
      r_op_we     <= 1'b0;
      r_op_uns    <= 1'b0;
      r_op_cross  <= 1'b0;
      r_op_size   <= SZ_B;
      r_op_off    <= '0;
      r_lo_rdata  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_op_we     <= req_we;
            r_op_uns    <= req_unsigned;
            r_op_size   <= w_size;
            r_op_off    <= w_off;
            r_op_cross  <= w_cross;
            r_next_word <= w_word + WORD_W'(1);
            r_hi_be     <= w_be_wide[BE2_W-1:NB];
            r_hi_wdata  <= w_wdata_wide[D2_W-1:DATA_W];
            if (w_cross) begin
              r_state <= SPLIT;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= w_err;
            end
          end
        end
        SPLIT: begin
          // First word's read data is on the RAM output now; keep it for the merge.
          r_lo_rdata  <= w_bank_rdata;
          r_rsp_valid <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Merge both words for a split load, then shift the first byte down to lane 0.
  assign w_gather = r_op_cross ? {w_bank_rdata, r_lo_rdata} : D2_W'(w_bank_rdata);
  assign w_raw    = DATA_W'(w_gather >> {r_op_off, 3'b000});

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = (r_rsp_valid && !r_rsp_err && !r_op_we)
                   ? DATA_W'(extend_load(32'(w_raw), r_op_size, r_op_uns))
                   : '0;

endmodule
`default_nettype wire
